// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-period derivation, 8N1 framing constant, frame FSM encoding.
// Pure declarations; no logic, no latency.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = 14;
    localparam int GAP_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // The extra cycle keeps the bit period slightly long rather than short.
    function automatic int clocks_per_bit(input int clock_speed, input int baud_rate);
        return (clock_speed / baud_rate) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchronizer, start/data/stop FSM, mid-bit sampling.
// Strobes are combinational in the stop-sample cycle; no backpressure, the line cannot be stalled.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_ferr_o,
    output logic       idle_o
);

    localparam logic [BIT_CNT_W-1:0] CPB_M1  = BIT_CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] HALF_M1 = BIT_CNT_W'(CLOCKS_PER_BIT / 2 - 1);

    logic                 sync1_q, sync2_q, prev_q;
    rx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]           bits_q, bits_d;
    logic [7:0]           shift_q, shift_d;
    logic                 rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bits_d       = bits_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        byte_ferr_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_valid_o = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        byte_ferr_o = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_o = shift_q;
    assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_rx16.sv
// Assembles two 8N1 frames (low byte first) into a 16-bit word with an inter-frame gap timeout.
// valid/frame_err/gap_err pulse one cycle after the deciding sample; no backpressure.
module uart_rx16
    import uart_pkg::*;
#(
    parameter int CLOCK_SPEED    = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int CLOCKS_PER_BIT = clocks_per_bit(CLOCK_SPEED, BAUD_RATE),
    parameter int GAP_BITS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] data,
    output logic        valid,
    output logic        frame_err,
    output logic        gap_err,
    output logic        busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_M1 = GAP_CNT_W'(GAP_BITS * CLOCKS_PER_BIT - 1);

    logic [7:0]           rx_byte;
    logic                 rx_valid, rx_ferr, rx_idle;
    logic                 phase_q, phase_d;
    logic [7:0]           lo_q, lo_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic [15:0]          data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, gerr_q, gerr_d;
    logic                 gap_expire;

    uart_rx_byte #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_rx_byte (
        .clk         (clk),
        .rst         (rst),
        .rxd_i       (rxd),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .byte_ferr_o (rx_ferr),
        .idle_o      (rx_idle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            lo_q    <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            gerr_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            lo_q    <= lo_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            gerr_q  <= gerr_d;
        end
    end

    // Expiry is checked before byte events, so a start edge in the expiry cycle becomes a new low byte.
    always_comb begin
        phase_d    = phase_q;
        lo_d       = lo_q;
        gap_d      = gap_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        gerr_d     = 1'b0;
        gap_expire = phase_q && rx_idle && (gap_q == GAP_M1);
        if (!phase_q) begin
            gap_d = '0;
        end else if (rx_idle) begin
            gap_d = gap_q + 1'b1;
        end
        if (gap_expire) begin
            gerr_d  = 1'b1;
            phase_d = 1'b0;
            lo_d    = '0;
            gap_d   = '0;
        end else if (rx_ferr) begin
            ferr_d  = 1'b1;
            phase_d = 1'b0;
            lo_d    = '0;
        end else if (rx_valid) begin
            if (phase_q) begin
                data_d  = {rx_byte, lo_q};
                valid_d = 1'b1;
                phase_d = 1'b0;
            end else begin
                lo_d    = rx_byte;
                phase_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign gap_err   = gerr_q;
    assign busy      = !rx_idle || phase_q;

endmodule

// File: tb/tb_uart_rx16.sv
// Scoreboard bench for uart_rx16: frame-level model queues expected events, a monitor checks them.
// Small CLOCK_SPEED/BAUD_RATE keep the bit period short.
module tb_uart_rx16;

    localparam int CLOCK_SPEED = 1_000_000;
    localparam int BAUD_RATE   = 62_500;
    localparam int CPB         = (CLOCK_SPEED / BAUD_RATE) + 1;
    localparam int H           = CPB / 2;
    localparam int GAP         = 4;
    localparam int K_VALID     = 0;
    localparam int K_FERR      = 1;
    localparam int K_GAP       = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] data;
    logic        valid, frame_err, gap_err, busy;

    uart_rx16 #(
        .CLOCK_SPEED(CLOCK_SPEED),
        .BAUD_RATE  (BAUD_RATE),
        .GAP_BITS   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .gap_err  (gap_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [15:0] dat;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          valid_times[$];
    int          checks = 0;
    int          passed = 0;
    logic [15:0] hold_dat = 16'h0;

    // Reference model: byte phase, held low byte, idle bits since the last stop.
    bit          m_phase = 1'b0;
    logic [7:0]  m_lo = 8'h0;
    int          m_stop_cyc = 0;
    int          m_idle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_bits(input logic v, input int ncyc);
        rxd = v;
        repeat (ncyc) @(negedge clk);
    endtask

    // Start edge driven in cycle n is seen on the synchronized line at n+2; stop sampled H+9*CPB later.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        int   s;
        s = cyc + 2 + H + 9 * CPB;
        e.dat = 16'h0;
        e.at  = s + 1;
        if (!stop_ok) begin
            e.kind = K_FERR;
            exp_q.push_back(e);
            m_phase = 1'b0;
        end else if (m_phase) begin
            e.kind = K_VALID;
            e.dat  = {b, m_lo};
            exp_q.push_back(e);
            m_phase = 1'b0;
        end else begin
            m_lo    = b;
            m_phase = 1'b1;
        end
        m_stop_cyc = s;
        m_idle     = 0;
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(stop_ok, CPB);
    endtask

    // Half a stop bit plus the idle bits is the gap; counts are whole bits so the limit is never borderline.
    task automatic idle_bits(input int n);
        exp_t e;
        m_idle = m_idle + n;
        if (m_phase && (2 * m_idle + 1 > 2 * GAP)) begin
            e.kind = K_GAP;
            e.dat  = 16'h0;
            e.at   = m_stop_cyc + GAP * CPB + 1;
            exp_q.push_back(e);
            m_phase = 1'b0;
        end
        drive_bits(1'b1, n * CPB);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_frame(w[7:0], 1'b1);
        idle_bits(gap);
        send_frame(w[15:8], 1'b1);
    endtask

    task automatic pop_cmp(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            if (e.kind == K_VALID) begin
                if (kind == K_VALID) check("valid_data", data, e.dat);
                hold_dat = e.dat;
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                hold_dat = 16'h0;
            end else begin
                if (valid) begin
                    valid_times.push_back(cyc);
                    pop_cmp(K_VALID);
                end else begin
                    check("data_hold", data, hold_dat);
                end
                if (frame_err) pop_cmp(K_FERR);
                if (gap_err) pop_cmp(K_GAP);
            end
        end
    end

    initial begin : stim
        int          n;
        int          w;
        logic [15:0] word;

        repeat (3) @(negedge clk);
        check("rst_data", data, 16'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_gap_err", gap_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle_bits(2);

        send_word(16'hA55A, 0);
        check("busy_after_word", busy, 1'b0);
        idle_bits(1);

        n = cyc;
        drive_bits(1'b0, CPB / 4);
        rxd = 1'b1;
        wait_cyc(n + 5);
        check("glitch_busy_high", busy, 1'b1);
        wait_cyc(n + 2 + H + 1);
        check("glitch_busy_low", busy, 1'b0);
        idle_bits(2);

        send_frame(8'hC3, 1'b0);
        idle_bits(2);
        send_word(16'h1234, 0);
        idle_bits(1);

        send_frame(8'h3C, 1'b1);
        idle_bits(5);
        send_word(16'hBEEF, 0);
        check("busy_after_gap_word", busy, 1'b0);
        idle_bits(1);

        word = 16'h5A96;
        send_frame(word[7:0], 1'b1);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bits(word[8 + i], CPB);
        drive_bits(word[11], CPB / 2);
        rst = 1'b1;
        rxd = 1'b1;
        m_phase = 1'b0;
        @(negedge clk);
        check("midreset_data", data, 16'h0);
        check("midreset_valid", valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_gap_err", gap_err, 1'b0);
        check("midreset_busy", busy, 1'b0);
        rst = 1'b0;
        idle_bits(2);
        send_word(16'h00FF, 0);
        idle_bits(1);

        valid_times.delete();
        send_word(16'h0001, 0);
        send_word(16'h8000, 0);
        idle_bits(1);
        check("b2b_valid_count", valid_times.size(), 2);
        if (valid_times.size() == 2) check("b2b_valid_spacing", valid_times[1] - valid_times[0], 20 * CPB);

        for (int i = 0; i < 30; i++) begin
            int op;
            op = $urandom_range(0, 5);
            if (op <= 3) begin
                send_frame(8'($urandom), 1'b1);
            end else if (op == 4) begin
                idle_bits($urandom_range(0, 6));
            end else begin
                send_frame(8'($urandom), 1'b0);
                idle_bits($urandom_range(1, 2));
            end
        end
        idle_bits(8);

        w = 0;
        while (exp_q.size() != 0 && w < 40 * CPB) begin
            @(negedge clk);
            w++;
        end
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            $display("FAIL missing_event: kind %0d never seen, required at cycle %0d", e.kind, e.at);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
